// File: rtl/hazard_unit_pkg.sv
// Shared pipeline definitions for the hazard unit:
// forward-select encodings and hazard FSM states.
package hazard_unit_pkg;

  localparam logic [1:0] FWD_RF = 2'b00;
  localparam logic [1:0] FWD_W  = 2'b01;
  localparam logic [1:0] FWD_M  = 2'b10;

  typedef enum logic [0:0] {
    RUN      = 1'b0,
    MEM_WAIT = 1'b1
  } hz_state_e;

endpackage

// File: rtl/hazard_unit_if.sv
// Pipeline <-> hazard unit bundle: register addresses and
// control in, stall/flush/forward selects and status out.
interface hazard_unit_if #(
  parameter int ADDR_WIDTH = 5
);
  logic [ADDR_WIDTH-1:0] Rs1D;
  logic [ADDR_WIDTH-1:0] Rs2D;
  logic [ADDR_WIDTH-1:0] Rs1E;
  logic [ADDR_WIDTH-1:0] Rs2E;
  logic [ADDR_WIDTH-1:0] RdE;
  logic [ADDR_WIDTH-1:0] RdM;
  logic [ADDR_WIDTH-1:0] RdW;
  logic MemReadE;
  logic RegWriteM;
  logic RegWriteW;
  logic PCSrcE;
  logic MemReqM;
  logic mem_ready;
  logic StallF;
  logic StallD;
  logic StallE;
  logic StallM;
  logic FlushD;
  logic FlushE;
  logic FlushW;
  logic [1:0] ForwardAE;
  logic [1:0] ForwardBE;
  logic mem_busy;
  logic mem_timeout;
  logic [31:0] stall_count;

  modport master (
    output Rs1D, Rs2D, Rs1E, Rs2E,
    output RdE, RdM, RdW,
    output MemReadE, RegWriteM, RegWriteW,
    output PCSrcE, MemReqM, mem_ready,
    input  StallF, StallD, StallE, StallM,
    input  FlushD, FlushE, FlushW,
    input  ForwardAE, ForwardBE,
    input  mem_busy, mem_timeout, stall_count
  );

  modport slave (
    input  Rs1D, Rs2D, Rs1E, Rs2E,
    input  RdE, RdM, RdW,
    input  MemReadE, RegWriteM, RegWriteW,
    input  PCSrcE, MemReqM, mem_ready,
    output StallF, StallD, StallE, StallM,
    output FlushD, FlushE, FlushW,
    output ForwardAE, ForwardBE,
    output mem_busy, mem_timeout, stall_count
  );
endinterface

// File: rtl/hazard_unit_forward.sv
// Operand forward select for one Execute source;
// the M stage result wins over the W stage result.
module forward_unit
  import hazard_unit_pkg::*;
#(
  parameter int ADDR_WIDTH = 5
) (
  input  logic [ADDR_WIDTH-1:0] rs,
  input  logic [ADDR_WIDTH-1:0] rd_m,
  input  logic [ADDR_WIDTH-1:0] rd_w,
  input  logic                  reg_write_m,
  input  logic                  reg_write_w,
  output logic [1:0]            fwd
);

  logic hit_m;
  logic hit_w;

  assign hit_m = reg_write_m && (rd_m != '0)
              && (rd_m == rs);
  assign hit_w = reg_write_w && (rd_w != '0)
              && (rd_w == rs);

  always_comb begin
    fwd = FWD_RF;
    if (hit_m)
      fwd = FWD_M;
    else if (hit_w)
      fwd = FWD_W;
  end

endmodule

// File: rtl/hazard_unit.sv
// Pipeline hazard unit: forwarding, load-use and branch
// hazards, data-memory wait FSM with timeout and stall stats.
module hazard_unit
  import hazard_unit_pkg::*;
#(
  parameter int ADDR_WIDTH = 5,
  parameter int TIMEOUT    = 255,
  parameter int CNT_WIDTH  = 8
) (
  input logic           clk,
  input logic           rst_n,
  hazard_unit_if.slave  hz
);

  localparam logic [CNT_WIDTH-1:0] TMO =
    CNT_WIDTH'(TIMEOUT);

  hz_state_e            state;
  logic [CNT_WIDTH-1:0] wait_cnt;
  logic                 timeout_q;
  logic [31:0]          stall_cnt;
  logic                 lw_stall;
  logic                 mem_stall;
  logic                 stall_f;
  logic                 stall_d;
  logic                 stall_e;
  logic                 stall_m;
  logic                 flush_d;
  logic                 flush_e;
  logic                 flush_w;

  forward_unit #(.ADDR_WIDTH(ADDR_WIDTH)) u_fwd_a (
    .rs          (hz.Rs1E),
    .rd_m        (hz.RdM),
    .rd_w        (hz.RdW),
    .reg_write_m (hz.RegWriteM),
    .reg_write_w (hz.RegWriteW),
    .fwd         (hz.ForwardAE)
  );

  forward_unit #(.ADDR_WIDTH(ADDR_WIDTH)) u_fwd_b (
    .rs          (hz.Rs2E),
    .rd_m        (hz.RdM),
    .rd_w        (hz.RdW),
    .reg_write_m (hz.RegWriteM),
    .reg_write_w (hz.RegWriteW),
    .fwd         (hz.ForwardBE)
  );

  assign lw_stall = hz.MemReadE && (hz.RdE != '0)
                 && ((hz.RdE == hz.Rs1D)
                  || (hz.RdE == hz.Rs2D));

  assign mem_stall = hz.MemReqM && !hz.mem_ready;

  // A frozen pipeline takes no bubbles; a pending branch
  // in E simply waits there until the freeze lifts.
  always_comb begin
    stall_f = 1'b0;
    stall_d = 1'b0;
    stall_e = 1'b0;
    stall_m = 1'b0;
    flush_d = 1'b0;
    flush_e = 1'b0;
    flush_w = 1'b0;
    if (mem_stall) begin
      stall_f = 1'b1;
      stall_d = 1'b1;
      stall_e = 1'b1;
      stall_m = 1'b1;
      flush_w = 1'b1;
    end else begin
      if (lw_stall) begin
        stall_f = 1'b1;
        stall_d = 1'b1;
        flush_e = 1'b1;
      end
      if (hz.PCSrcE) begin
        flush_d = 1'b1;
        flush_e = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= RUN;
    end else begin
      case (state)
        RUN:      if (mem_stall)  state <= MEM_WAIT;
        MEM_WAIT: if (!mem_stall) state <= RUN;
        default:  state <= RUN;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wait_cnt  <= '0;
      timeout_q <= 1'b0;
    end else if (state == RUN) begin
      wait_cnt <= '0;
    end else begin
      if (wait_cnt != TMO)
        wait_cnt <= wait_cnt + CNT_WIDTH'(1);
      if (wait_cnt == TMO)
        timeout_q <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      stall_cnt <= '0;
    else if (stall_d && (stall_cnt != '1))
      stall_cnt <= stall_cnt + 32'd1;
  end

  assign hz.StallF      = stall_f;
  assign hz.StallD      = stall_d;
  assign hz.StallE      = stall_e;
  assign hz.StallM      = stall_m;
  assign hz.FlushD      = flush_d;
  assign hz.FlushE      = flush_e;
  assign hz.FlushW      = flush_w;
  assign hz.mem_busy    = (state == MEM_WAIT);
  assign hz.mem_timeout = timeout_q;
  assign hz.stall_count = stall_cnt;

endmodule

// File: tb/tb_hazard_unit.sv
// Self-checking bench for hazard_unit: vector table,
// directed multi-cycle sequences and a random reference run.
module tb_hazard_unit;

  localparam int AW  = 5;
  localparam int TMO = 4;

  logic clk;
  logic rst_n;
  int   errors;
  int   checks;

  hazard_unit_if #(.ADDR_WIDTH(AW)) hz();

  hazard_unit #(
    .ADDR_WIDTH (AW),
    .TIMEOUT    (TMO),
    .CNT_WIDTH  (8)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .hz    (hz)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [AW-1:0] rs1d, rs2d, rs1e, rs2e;
    logic [AW-1:0] rde, rdm, rdw;
    logic mre, rwm, rww, pcs, mrq, rdy;
    logic [1:0] fa, fb;
    logic [3:0] st;
    logic [2:0] fl;
  } vec_t;

  vec_t tbl[13];

  // reference model state
  bit m_busy;
  int m_wait;
  bit m_tmo;
  int m_sc;

  function automatic vec_t mkv(
    int rs1d, int rs2d, int rs1e, int rs2e,
    int rde, int rdm, int rdw,
    bit mre, bit rwm, bit rww, bit pcs,
    bit mrq, bit rdy,
    int fa, int fb, int st, int fl);
    vec_t v;
    v.rs1d = AW'(rs1d); v.rs2d = AW'(rs2d);
    v.rs1e = AW'(rs1e); v.rs2e = AW'(rs2e);
    v.rde  = AW'(rde);  v.rdm  = AW'(rdm);
    v.rdw  = AW'(rdw);
    v.mre = mre; v.rwm = rwm; v.rww = rww;
    v.pcs = pcs; v.mrq = mrq; v.rdy = rdy;
    v.fa = 2'(fa); v.fb = 2'(fb);
    v.st = 4'(st); v.fl = 3'(fl);
    return v;
  endfunction

  task automatic chk(string name, logic [31:0] act,
                     logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h",
               name, act, exp);
    end
  endtask

  task automatic clear_in();
    hz.Rs1D = '0; hz.Rs2D = '0;
    hz.Rs1E = '0; hz.Rs2E = '0;
    hz.RdE = '0; hz.RdM = '0; hz.RdW = '0;
    hz.MemReadE = 0; hz.RegWriteM = 0;
    hz.RegWriteW = 0; hz.PCSrcE = 0;
    hz.MemReqM = 0; hz.mem_ready = 1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    clear_in();
    rst_n = 0;
    #2;
    tick();
    rst_n = 1;
  endtask

  function automatic logic [3:0] stalls();
    return {hz.StallF, hz.StallD, hz.StallE, hz.StallM};
  endfunction

  function automatic logic [2:0] flushes();
    return {hz.FlushD, hz.FlushE, hz.FlushW};
  endfunction

  function automatic logic [1:0] fwd_ref(
    logic [AW-1:0] rs);
    if (hz.RegWriteM && hz.RdM != 0 && hz.RdM == rs)
      return 2'b10;
    if (hz.RegWriteW && hz.RdW != 0 && hz.RdW == rs)
      return 2'b01;
    return 2'b00;
  endfunction

  task automatic model_check();
    bit ms, lu, br;
    ms = hz.MemReqM && !hz.mem_ready;
    lu = hz.MemReadE && hz.RdE != 0
      && (hz.RdE == hz.Rs1D || hz.RdE == hz.Rs2D);
    br = hz.PCSrcE && !ms;
    chk("rnd_fa", 32'(hz.ForwardAE), 32'(fwd_ref(hz.Rs1E)));
    chk("rnd_fb", 32'(hz.ForwardBE), 32'(fwd_ref(hz.Rs2E)));
    chk("rnd_stall", 32'(stalls()),
        32'({ms || lu, ms || lu, ms, ms}));
    chk("rnd_flush", 32'(flushes()),
        32'({br, br || (lu && !ms), ms}));
    chk("rnd_busy", 32'(hz.mem_busy), 32'(m_busy));
    chk("rnd_tmo", 32'(hz.mem_timeout), 32'(m_tmo));
    chk("rnd_scnt", hz.stall_count, 32'(m_sc));
  endtask

  // Advance the model across one clock edge.
  task automatic model_edge();
    bit ms, lu;
    ms = hz.MemReqM && !hz.mem_ready;
    lu = hz.MemReadE && hz.RdE != 0
      && (hz.RdE == hz.Rs1D || hz.RdE == hz.Rs2D);
    if (m_busy) begin
      m_wait++;
      if (m_wait > TMO) m_tmo = 1;
    end
    if (ms || lu) m_sc++;
    m_busy = ms;
    if (!ms) m_wait = 0;
  endtask

  initial begin
    errors = 0;
    checks = 0;
    rst_n  = 1;
    clear_in();

    //             rs1d rs2d rs1e rs2e rde rdm rdw
    //             mre rwm rww pcs mrq rdy fa fb st fl
    tbl[0]  = mkv(0,0,5,0, 0,5,5, 0,1,1,0,0,1, 2,0, 0,0);
    tbl[1]  = mkv(0,0,5,0, 0,5,5, 0,0,1,0,0,1, 1,0, 0,0);
    tbl[2]  = mkv(0,0,5,0, 0,0,0, 0,1,1,0,0,1, 0,0, 0,0);
    tbl[3]  = mkv(0,0,7,7, 0,7,7, 0,1,1,0,0,1, 2,2, 0,0);
    tbl[4]  = mkv(0,0,2,3, 0,3,2, 0,1,1,0,0,1, 1,2, 0,0);
    tbl[5]  = mkv(0,3,0,0, 3,0,0, 1,0,0,0,0,1, 0,0, 12,2);
    tbl[6]  = mkv(0,0,0,0, 0,0,0, 1,0,0,0,0,1, 0,0, 0,0);
    tbl[7]  = mkv(0,0,0,0, 0,0,0, 0,0,0,1,0,1, 0,0, 0,6);
    tbl[8]  = mkv(4,0,0,0, 4,0,0, 1,0,0,1,0,1, 0,0, 12,6);
    tbl[9]  = mkv(4,0,0,0, 4,0,0, 1,0,0,1,1,0, 0,0, 15,1);
    tbl[10] = mkv(0,0,0,0, 0,0,0, 0,0,0,1,1,1, 0,0, 0,6);
    tbl[11] = mkv(6,0,0,0, 6,0,0, 1,1,1,0,0,1, 0,0, 12,2);
    tbl[12] = mkv(5,7,0,0, 6,0,0, 1,0,0,0,0,1, 0,0, 0,0);

    // reset state
    rst_n = 0;
    #2;
    chk("rst_busy", 32'(hz.mem_busy), 0);
    chk("rst_tmo", 32'(hz.mem_timeout), 0);
    chk("rst_scnt", hz.stall_count, 0);
    do_reset();

    for (int i = 0; i < 13; i++) begin
      hz.Rs1D = tbl[i].rs1d; hz.Rs2D = tbl[i].rs2d;
      hz.Rs1E = tbl[i].rs1e; hz.Rs2E = tbl[i].rs2e;
      hz.RdE = tbl[i].rde; hz.RdM = tbl[i].rdm;
      hz.RdW = tbl[i].rdw;
      hz.MemReadE = tbl[i].mre;
      hz.RegWriteM = tbl[i].rwm;
      hz.RegWriteW = tbl[i].rww;
      hz.PCSrcE = tbl[i].pcs;
      hz.MemReqM = tbl[i].mrq;
      hz.mem_ready = tbl[i].rdy;
      #1;
      chk($sformatf("vec%0d_fa", i),
          32'(hz.ForwardAE), 32'(tbl[i].fa));
      chk($sformatf("vec%0d_fb", i),
          32'(hz.ForwardBE), 32'(tbl[i].fb));
      chk($sformatf("vec%0d_stall", i),
          32'(stalls()), 32'(tbl[i].st));
      chk($sformatf("vec%0d_flush", i),
          32'(flushes()), 32'(tbl[i].fl));
      tick();
    end

    // load-use stall counted once
    do_reset();
    hz.MemReadE = 1; hz.RdE = 3; hz.Rs2D = 3;
    #1;
    chk("lu_stall", 32'(stalls()), 32'hC);
    chk("lu_cnt0", hz.stall_count, 0);
    tick();
    chk("lu_cnt1", hz.stall_count, 1);
    clear_in();
    tick();
    chk("lu_cnt_hold", hz.stall_count, 1);

    // 3-cycle memory stall with branch deferred
    do_reset();
    hz.MemReqM = 1; hz.mem_ready = 0; hz.PCSrcE = 1;
    for (int c = 0; c < 3; c++) begin
      #1;
      chk($sformatf("ms%0d_stall", c),
          32'(stalls()), 32'hF);
      chk($sformatf("ms%0d_flush", c),
          32'(flushes()), 32'h1);
      chk($sformatf("ms%0d_busy", c),
          32'(hz.mem_busy), (c == 0) ? 0 : 1);
      tick();
    end
    hz.mem_ready = 1;
    #1;
    chk("ms_rel_stall", 32'(stalls()), 0);
    chk("ms_rel_flush", 32'(flushes()), 32'h6);
    chk("ms_rel_busy", 32'(hz.mem_busy), 1);
    chk("ms_rel_scnt", hz.stall_count, 3);
    tick();
    chk("ms_done_busy", 32'(hz.mem_busy), 0);

    // timeout after the fifth wait cycle, sticky
    do_reset();
    hz.MemReqM = 1; hz.mem_ready = 0;
    for (int e = 1; e <= 5; e++) tick();
    chk("tmo_before", 32'(hz.mem_timeout), 0);
    tick();
    chk("tmo_set", 32'(hz.mem_timeout), 1);
    hz.mem_ready = 1;
    tick();
    tick();
    chk("tmo_sticky", 32'(hz.mem_timeout), 1);
    chk("tmo_run", 32'(hz.mem_busy), 0);
    rst_n = 0;
    #1;
    chk("tmo_rst", 32'(hz.mem_timeout), 0);
    rst_n = 1;

    // asynchronous reset in the middle of a wait
    do_reset();
    hz.MemReqM = 1; hz.mem_ready = 0;
    tick();
    tick();
    chk("ar_busy", 32'(hz.mem_busy), 1);
    #1;
    rst_n = 0;
    #1;
    chk("ar_busy_rst", 32'(hz.mem_busy), 0);
    chk("ar_comb_rst", 32'(stalls()), 32'hF);
    hz.mem_ready = 1;
    #1;
    rst_n = 1;
    #1;
    chk("ar_nostall", 32'(stalls()), 0);
    tick();
    chk("ar_busy_rel", 32'(hz.mem_busy), 0);
    chk("ar_scnt", hz.stall_count, 0);

    // random run against the reference model
    do_reset();
    m_busy = 0; m_wait = 0; m_tmo = 0; m_sc = 0;
    for (int n = 0; n < 400; n++) begin
      hz.Rs1D = AW'($urandom_range(3));
      hz.Rs2D = AW'($urandom_range(3));
      hz.Rs1E = AW'($urandom_range(3));
      hz.Rs2E = AW'($urandom_range(3));
      hz.RdE = AW'($urandom_range(3));
      hz.RdM = AW'($urandom_range(3));
      hz.RdW = AW'($urandom_range(3));
      hz.MemReadE = 1'($urandom);
      hz.RegWriteM = 1'($urandom);
      hz.RegWriteW = 1'($urandom);
      hz.PCSrcE = ($urandom_range(3) == 0);
      hz.MemReqM = ($urandom_range(2) == 0);
      hz.mem_ready = (n >= 200 && n < 215)
                   ? 1'b0 : ($urandom_range(2) != 0);
      #2;
      model_check();
      @(posedge clk);
      model_edge();
      #1;
    end

    $display("Result: errors=%0d of %0d checks",
             errors, checks);
    $finish;
  end

endmodule

// File: doc/hazard_unit.md
HAZARD_UNIT -- requirements
Module: hazard_unit

Interface
REQ-001 SHALL have parameters: ADDR_WIDTH, default 5, register-address width; TIMEOUT, default 255, memory-wait cycles before timeout flag; CNT_WIDTH, default 8, wait-counter width (holds TIMEOUT).
REQ-002 SHALL have exactly one clock and one reset. clk input 1: clock, all state updates on posedge. rst_n input 1: asynchronous active-low reset.
REQ-003 SHALL have these register-address inputs, each ADDR_WIDTH wide: Rs1D and Rs2D (Decode sources); Rs1E and Rs2E (Execute sources); RdE, RdM and RdW (destinations in E, M and W).
REQ-004 SHALL have these 1-bit inputs: MemReadE (load in E); RegWriteM; RegWriteW; PCSrcE (taken branch or jump resolved in E); MemReqM (MemRead or MemWrite in M); mem_ready (data memory completes access this cycle).
REQ-005 SHALL have these 1-bit outputs: StallF, StallD, StallE, StallM (hold stage register); FlushD, FlushE, FlushW (synchronous bubble into stage register).
REQ-006 SHALL have ForwardAE and ForwardBE, output, 2 bits each, Execute operand select: 00 = register file, 01 = W result, 10 = M result.
REQ-007 SHALL have these status outputs: mem_busy, output 1, FSM in MEM_WAIT; mem_timeout, output 1, sticky timeout flag; stall_count, output 32, saturating count of cycles with StallD=1.

Function
REQ-008 SHALL select ForwardAE=10 when RegWriteM=1, RdM!=0 and RdM==Rs1E; else 01 when RegWriteW=1, RdW!=0 and RdW==Rs1E; else 00. ForwardBE uses the same rule on Rs2E. M has priority over W.
REQ-009 SHALL compute lw_stall = MemReadE & (RdE!=0) & ((RdE==Rs1D)|(RdE==Rs2D)).
REQ-010 SHALL compute mem_stall = MemReqM & ~mem_ready, combinationally, in every state.
REQ-011 Mem stall: when mem_stall=1, StallF=StallD=StallE=StallM=1 and FlushW=1. FlushD=FlushE=0 in the same cycle (the pipeline freezes; no bubble enters frozen stages).
REQ-012 Load-use stall: when mem_stall=0 and lw_stall=1, StallF=StallD=1 and FlushE=1.
REQ-013 Branch: when mem_stall=0 and PCSrcE=1, FlushD=1 and FlushE=1. If lw_stall is also 1, StallF and StallD remain asserted with the flushes.
REQ-014 Deferred branch: a PCSrcE held during a mem stall SHALL produce its flushes in the first cycle with mem_stall=0. No extra state is needed, because E is frozen.
REQ-015 All stall and flush outputs are combinational, zero-cycle latency. Outputs not named by an active rule are 0.
REQ-016 FSM has two states: RUN and MEM_WAIT. RUN goes to MEM_WAIT when mem_stall=1. MEM_WAIT goes to RUN when mem_stall=0. mem_busy=1 only in MEM_WAIT.
REQ-017 Wait counter clears on entry to MEM_WAIT and in RUN. It increments each MEM_WAIT cycle and saturates at TIMEOUT.
REQ-018 When the counter reaches TIMEOUT in MEM_WAIT, mem_timeout SHALL be set on the next edge. It stays 1 until reset. Stalling continues; there is no abort.
REQ-019 stall_count increments on each posedge where StallD=1 and saturates at 0xFFFF_FFFF.
REQ-020 A mem_ready arriving in the same cycle as a new MemReqM SHALL cause no stall and no FSM transition.

Reset
REQ-021 When rst_n=0, asynchronously: state=RUN, wait counter=0, mem_timeout=0, stall_count=0, mem_busy=0.
REQ-022 Reset mid-wait SHALL abandon MEM_WAIT immediately. After release, behaviour depends only on current inputs.
REQ-023 Combinational outputs SHALL follow inputs during reset. The stage registers are themselves reset by rst_n.

Structure
REQ-024 The forward-select encodings (FWD_RF, FWD_W, FWD_M) and the FSM state enum SHALL live in the shared pipeline package.
REQ-025 Forwarding SHALL be one sub-module, forward_unit, instantiated twice (operand A and operand B). FSM, counters and stall/flush logic stay in hazard_unit.

Verification
REQ-026 RdM=5, RegWriteM=1, RdW=5, RegWriteW=1, Rs1E=5 -> ForwardAE=10. Then RegWriteM=0 -> 01. Then RdM=RdW=0 -> 00.
REQ-027 MemReadE=1, RdE=3, Rs2D=3, mem_stall=0 -> StallF=StallD=FlushE=1 for one cycle, and stall_count 0->1.
REQ-028 MemReqM=1, mem_ready=0 for 3 cycles, then 1 -> Stall{F,D,E,M}=FlushW=1 for 3 cycles, and mem_busy=1 for 3 cycles. With PCSrcE=1 held throughout, FlushD=FlushE=1 only in the release cycle.
REQ-029 TIMEOUT=4, mem_ready held 0 -> mem_timeout rises after the 5th wait cycle and stays 1 after mem_ready=1. rst_n=0 clears it.
REQ-030 rst_n pulsed low during MEM_WAIT -> mem_busy=0 immediately and counter=0. After release with mem_ready=1, no stall.
REQ-031 lw_stall=1 and PCSrcE=1 together -> StallF=StallD=1, FlushD=FlushE=1, FlushW=0.
